// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } addsub_state_e;

  // Width of the slice index; never zero, so a single-slice unit still has a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// CHUNK-bit ripple-carry slice; also exposes the carry into its top bit for overflow detection.
module addsub_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    sum    = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub_unit.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, valid/ready on both sides,
// carry/overflow/zero/negative flags and optional signed saturation.
module chunked_addsub_unit
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned IdxW   = idx_width(NChunk);

  localparam logic [WIDTH-1:0] SatNeg  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SatPos  = ~SatNeg;
  localparam logic [WIDTH-1:0] MaskLow = WIDTH'({CHUNK{1'b1}});

  addsub_state_e   r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sat;
  logic             r_carry;
  logic [IdxW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic             r_out_valid;

  logic [31:0]      w_shift;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_c_msb;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_s_final;

  addsub_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout),
    .c_msb(w_slice_c_msb)
  );

  // Select the current slice of the operands and merge its sum into the accumulated result.
  always_comb begin
    w_shift    = 32'(r_idx) * CHUNK;
    w_a_slice  = CHUNK'(r_a >> w_shift);
    w_b_slice  = CHUNK'(r_b >> w_shift);
    w_sum_next = (r_sum & ~(MaskLow << w_shift)) | (WIDTH'(w_slice_sum) << w_shift);
    w_last     = (r_idx == IdxW'(NChunk - 1));
    // On the top slice c_msb is the carry into bit WIDTH-1.
    w_ovf      = w_slice_c_msb ^ w_slice_cout;
    w_s_final  = w_sum_next;
    if (r_sat && w_ovf) begin
      w_s_final = r_a[WIDTH-1] ? SatNeg : SatPos;
    end
  end

  // FSM with operand, carry and registered result/flag state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_sat       <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_sat   <= sat;
            r_carry <= sub;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + IdxW'(1);
          if (w_last) begin
            r_idx       <= '0;
            r_s         <= w_s_final;
            r_cout      <= w_slice_cout;
            r_ovf       <= w_ovf;
            r_zero      <= (w_s_final == '0);
            r_neg       <= w_s_final[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Scoreboard bench: a reference model predicts each accepted operation; results and latency
// are compared when the unit hands them out.
module tb_chunked_addsub_unit;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic [31:0] acc;
  } exp_t;

  logic        clk;
  logic [31:0] cyc;
  int unsigned n_checks;
  int unsigned n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Plain-arithmetic reference for a w-bit add/subtract with optional saturation.
  function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                                 input logic isat, input int unsigned w);
    exp_t        e;
    logic [63:0] mask, am, bm, full, raw, res, sneg;
    mask   = (64'd1 << w) - 64'd1;
    am     = {32'b0, ia} & mask;
    bm     = (isub ? ~{32'b0, ib} : {32'b0, ib}) & mask;
    full   = am + bm + {63'b0, isub};
    raw    = full & mask;
    e      = '0;
    e.cout = full[w];
    e.ovf  = (am[w-1] == bm[w-1]) && (raw[w-1] != am[w-1]);
    sneg   = 64'd1 << (w - 1);
    res    = raw;
    if (isat && e.ovf) res = am[w-1] ? sneg : (sneg - 64'd1);
    e.s    = res[31:0];
    e.zero = (res == 64'd0);
    e.neg  = res[w-1];
    return e;
  endfunction

  function automatic int unsigned sw_w(input int i);
    return (i == 2) ? 32 : 16;
  endfunction

  function automatic int unsigned sw_c(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 1 : 8);
  endfunction

  // ---------------- main instance, WIDTH=16 CHUNK=4 ----------------
  logic        m_reset, m_in_valid, m_in_ready, m_sub, m_sat, m_out_valid, m_out_ready;
  logic        m_cout, m_ovf, m_zero, m_neg, m_prev_ov;
  logic [15:0] m_a, m_b, m_s;
  exp_t        m_sb[$];

  chunked_addsub_unit #(
    .WIDTH(16),
    .CHUNK(4)
  ) u_dut (
    .clk      (clk),
    .reset    (m_reset),
    .in_valid (m_in_valid),
    .in_ready (m_in_ready),
    .a        (m_a),
    .b        (m_b),
    .sub      (m_sub),
    .sat      (m_sat),
    .out_valid(m_out_valid),
    .out_ready(m_out_ready),
    .s        (m_s),
    .cout     (m_cout),
    .ovf      (m_ovf),
    .zero     (m_zero),
    .neg      (m_neg)
  );

  task automatic m_monitor();
    exp_t e;
    if (m_in_valid && m_in_ready) begin
      e     = model({16'b0, m_a}, {16'b0, m_b}, m_sub, m_sat, 16);
      e.acc = cyc + 32'd1;
      m_sb.push_back(e);
    end
    if (m_out_valid && !m_prev_ov) begin
      if (m_sb.size() == 0) check_eq("m_spurious_valid", 64'd1, 64'd0);
      else check_eq("m_latency", 64'(cyc - m_sb[0].acc), 64'd4);
    end
    if (m_out_valid && m_out_ready) begin
      if (m_sb.size() == 0) begin
        check_eq("m_unexpected_out", 64'd1, 64'd0);
      end else begin
        e = m_sb.pop_front();
        check_eq("m_s", 64'(m_s), 64'(e.s));
        check_eq("m_cout", 64'(m_cout), 64'(e.cout));
        check_eq("m_ovf", 64'(m_ovf), 64'(e.ovf));
        check_eq("m_zero", 64'(m_zero), 64'(e.zero));
        check_eq("m_neg", 64'(m_neg), 64'(e.neg));
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_reset) m_prev_ov <= 1'b0;
    else begin
      m_monitor();
      m_prev_ov <= m_out_valid;
    end
  end

  task automatic m_wait_drain();
    int t;
    t = 0;
    while ((m_sb.size() != 0 || m_out_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) check_eq("m_drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic m_run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                          input logic tsat);
    int t;
    m_a        = ta;
    m_b        = tb;
    m_sub      = tsub;
    m_sat      = tsat;
    m_in_valid = 1'b1;
    t = 0;
    while (!m_in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) check_eq("m_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    m_wait_drain();
  endtask

  task automatic m_check_cleared(input string tag);
    check_eq({tag, "_s"}, 64'(m_s), 64'd0);
    check_eq({tag, "_flags"}, 64'({m_cout, m_ovf, m_zero, m_neg}), 64'd0);
    check_eq({tag, "_out_valid"}, 64'(m_out_valid), 64'd0);
    check_eq({tag, "_in_ready"}, 64'(m_in_ready), 64'd1);
  endtask

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned W = sw_w(g);
    localparam int unsigned C = sw_c(g);
    localparam int unsigned N = W / C;

    logic         rst, in_valid, in_ready, sub, sat, out_valid, out_ready;
    logic         cout, ovf, zero, neg, prev_ov, done;
    logic [W-1:0] a, b, s;
    exp_t         sb[$];

    chunked_addsub_unit #(
      .WIDTH(W),
      .CHUNK(C)
    ) u_dut (
      .clk      (clk),
      .reset    (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .sat      (sat),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s),
      .cout     (cout),
      .ovf      (ovf),
      .zero     (zero),
      .neg      (neg)
    );

    task automatic monitor();
      exp_t e;
      if (in_valid && in_ready) begin
        e     = model(32'(a), 32'(b), sub, sat, W);
        e.acc = cyc + 32'd1;
        sb.push_back(e);
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check_eq("sw_spurious_valid", 64'd1, 64'd0);
        else check_eq("sw_latency", 64'(cyc - sb[0].acc), 64'(N));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sw_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("sw_s", 64'(s), 64'(e.s));
          check_eq("sw_flags", 64'({cout, ovf, zero, neg}), 64'({e.cout, e.ovf, e.zero, e.neg}));
        end
      end
    endtask

    always @(negedge clk) begin
      if (rst) prev_ov <= 1'b0;
      else begin
        monitor();
        prev_ov <= out_valid;
      end
    end

    initial begin
      int t;
      done      = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      sat       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 25; i++) begin
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom_range(0, 1));
        sat = 1'($urandom_range(0, 1));
        if (i % 6 == 0) begin
          a = (i % 12 == 0) ? ~(W'(1) << (W - 1)) : (W'(1) << (W - 1));
          b = W'(1);
        end
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
          @(posedge clk);
          #1;
          t++;
        end
        if (t >= 100) check_eq("sw_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          t++;
        end
        if (t >= 200) check_eq("sw_drain_timeout", 64'd0, 64'd1);
      end
      done = 1'b1;
    end
  end

  // ---------------- directed sequence on the main instance ----------------
  initial begin
    exp_t e;
    int   t;
    n_checks    = 0;
    n_pass      = 0;
    m_reset     = 1'b1;
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    m_a         = '0;
    m_b         = '0;
    m_sub       = 1'b0;
    m_sat       = 1'b0;
    @(posedge clk);
    #1;
    m_check_cleared("reset");
    @(posedge clk);
    #1;
    m_reset = 1'b0;

    m_run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    m_run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    m_run_op(16'h00AB, 16'h00AB, 1'b1, 1'b0);
    m_run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    m_run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    m_run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    m_run_op(16'h8000, 16'hFFFF, 1'b0, 1'b1);

    // Back-pressure: hold the result in DONE while a new operand waits.
    m_out_ready = 1'b0;
    m_a         = 16'h4000;
    m_b         = 16'h4000;
    m_sub       = 1'b0;
    m_sat       = 1'b1;
    m_in_valid  = 1'b1;
    @(posedge clk);
    #1;
    m_a   = 16'h1111;
    m_b   = 16'h2222;
    m_sat = 1'b0;
    t = 0;
    while (!m_out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) check_eq("bp_valid_timeout", 64'd0, 64'd1);
    e = model(32'h4000, 32'h4000, 1'b0, 1'b1, 16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_s", 64'(m_s), 64'(e.s));
      check_eq("bp_flags", 64'({m_cout, m_ovf, m_zero, m_neg}),
               64'({e.cout, e.ovf, e.zero, e.neg}));
      check_eq("bp_in_ready", 64'(m_in_ready), 64'd0);
      check_eq("bp_out_valid", 64'(m_out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    m_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_in_ready_after", 64'(m_in_ready), 64'd1);
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    m_wait_drain();

    // Reset in the middle of an operation, after two slices.
    m_a        = 16'h0F0F;
    m_b        = 16'h0101;
    m_sub      = 1'b0;
    m_sat      = 1'b0;
    m_in_valid = 1'b1;
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset = 1'b1;
    #1;
    m_check_cleared("midrun_reset");
    m_sb.delete();
    @(posedge clk);
    #1;
    m_reset = 1'b0;
    check_eq("post_reset_in_ready", 64'(m_in_ready), 64'd1);
    m_run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);

    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) check_eq("sweep_timeout", 64'd0, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
